// File: rtl/div_sched_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// div_sched_pkg : divide op one-hot encodings and scheduler states (rev 1.0)
// ------------------------------------------------------------------------
package div_sched_pkg;

   localparam logic [3:0] DIV_OP_DIV_W  = 4'b0001;
   localparam logic [3:0] DIV_OP_MOD_W  = 4'b0010;
   localparam logic [3:0] DIV_OP_DIV_WU = 4'b0100;
   localparam logic [3:0] DIV_OP_MOD_WU = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

   // Quotient wanted? Lowest set bit wins: div.w > mod.w > div.wu > mod.wu.
   function automatic logic op_is_quot(input logic [2:0] op);
      return op[0] | (~op[1] & op[2]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/div_sched_axis_src_chan.sv
`default_nettype none
// ------------------------------------------------------------------------
// axis_src_chan : AXI-stream source tvalid register with handshake-done flag (rev 1.0)
// ------------------------------------------------------------------------
module axis_src_chan (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_tready,
   output logic o_tvalid,
   output logic o_sent
);

   logic r_tvalid;
   logic r_sent;

   // Once raised, tvalid only falls on its own handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tvalid <= 1'b0;
         r_sent   <= 1'b0;
      end else if (i_start) begin
         r_tvalid <= 1'b1;
         r_sent   <= 1'b0;
      end else if (r_tvalid && i_tready) begin
         r_tvalid <= 1'b0;
         r_sent   <= 1'b1;
      end
   end

   assign o_tvalid = r_tvalid;
   assign o_sent   = r_sent;

endmodule
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// ------------------------------------------------------------------------
// div_sched : EX-stage scheduler for the signed/unsigned AXI-stream dividers (rev 1.0)
// ------------------------------------------------------------------------
module div_sched
   import div_sched_pkg::*;
#(
   parameter int DIV_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [3:0]         req_op,
   input  logic [DIV_W-1:0]   req_src1,
   input  logic [DIV_W-1:0]   req_src2,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [DIV_W-1:0]   resp_data,
   output logic               busy,
   output logic               s_dividend_tvalid,
   input  logic               s_dividend_tready,
   output logic [DIV_W-1:0]   s_dividend_tdata,
   output logic               s_divisor_tvalid,
   input  logic               s_divisor_tready,
   output logic [DIV_W-1:0]   s_divisor_tdata,
   input  logic               s_dout_tvalid,
   input  logic [2*DIV_W-1:0] s_dout_tdata,
   output logic               u_dividend_tvalid,
   input  logic               u_dividend_tready,
   output logic [DIV_W-1:0]   u_dividend_tdata,
   output logic               u_divisor_tvalid,
   input  logic               u_divisor_tready,
   output logic [DIV_W-1:0]   u_divisor_tdata,
   input  logic               u_dout_tvalid,
   input  logic [2*DIV_W-1:0] u_dout_tdata
);

   div_state_e         r_state, w_state_next;
   logic [DIV_W-1:0]   r_src1, r_src2, r_resp_data;
   logic               r_is_signed, r_quot, r_drop;
   logic               w_accept, w_op_nz, w_issue;
   logic               w_dvd_tvalid, w_dvs_tvalid, w_dvd_sent, w_dvs_sent;
   logic               w_dvd_tready, w_dvs_tready, w_send_done;
   logic               w_dout_valid;
   logic [2*DIV_W-1:0] w_dout_data;

   assign req_ready    = (r_state == ST_IDLE) && !flush;
   assign w_accept     = req_valid && req_ready;
   assign w_op_nz      = |req_op;
   assign w_issue      = w_accept && w_op_nz;

   assign w_dvd_tready = r_is_signed ? s_dividend_tready : u_dividend_tready;
   assign w_dvs_tready = r_is_signed ? s_divisor_tready  : u_divisor_tready;
   assign w_dout_valid = r_is_signed ? s_dout_tvalid     : u_dout_tvalid;
   assign w_dout_data  = r_is_signed ? s_dout_tdata      : u_dout_tdata;

   // A channel counts as done if it already handshook or handshakes this cycle.
   assign w_send_done = (w_dvd_sent || (w_dvd_tvalid && w_dvd_tready)) &&
                        (w_dvs_sent || (w_dvs_tvalid && w_dvs_tready));

   axis_src_chan u_dvd_chan (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_issue),
      .i_tready (w_dvd_tready),
      .o_tvalid (w_dvd_tvalid),
      .o_sent   (w_dvd_sent)
   );

   axis_src_chan u_dvs_chan (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_issue),
      .i_tready (w_dvs_tready),
      .o_tvalid (w_dvs_tvalid),
      .o_sent   (w_dvs_sent)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)     w_state_next = w_op_nz ? ST_SEND : ST_DONE;
         ST_SEND: if (w_send_done)  w_state_next = ST_WAIT;
         ST_WAIT: if (w_dout_valid) w_state_next = (r_drop || flush) ? ST_IDLE : ST_DONE;
         ST_DONE: if (flush || resp_ready) w_state_next = ST_IDLE;
         default:                   w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_src1      <= '0;
         r_src2      <= '0;
         r_is_signed <= 1'b0;
         r_quot      <= 1'b0;
         r_resp_data <= '0;
         r_drop      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_src1      <= req_src1;
            r_src2      <= req_src2;
            r_is_signed <= req_op[0] | req_op[1];
            r_quot      <= op_is_quot(req_op[2:0]);
            if (!w_op_nz) r_resp_data <= '0;
         end
         if ((r_state == ST_WAIT) && w_dout_valid && !r_drop && !flush)
            r_resp_data <= r_quot ? w_dout_data[2*DIV_W-1:DIV_W] : w_dout_data[DIV_W-1:0];
         if (w_state_next == ST_IDLE)
            r_drop <= 1'b0;
         else if (flush && ((r_state == ST_SEND) || (r_state == ST_WAIT)))
            r_drop <= 1'b1;
      end
   end

   assign resp_valid        = (r_state == ST_DONE) && !r_drop && !flush;
   assign resp_data         = r_resp_data;
   assign busy              = (r_state != ST_IDLE);

   assign s_dividend_tvalid = w_dvd_tvalid &&  r_is_signed;
   assign s_divisor_tvalid  = w_dvs_tvalid &&  r_is_signed;
   assign u_dividend_tvalid = w_dvd_tvalid && !r_is_signed;
   assign u_divisor_tvalid  = w_dvs_tvalid && !r_is_signed;
   assign s_dividend_tdata  = r_src1;
   assign s_divisor_tdata   = r_src2;
   assign u_dividend_tdata  = r_src1;
   assign u_divisor_tdata   = r_src2;

endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_div_sched : directed self-checking bench for div_sched (rev 1.0)
// ------------------------------------------------------------------------
module tb_div_sched;
   import div_sched_pkg::*;

   logic        clk = 1'b0;
   logic        reset, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
   logic [3:0]  req_op;
   logic [31:0] req_src1, req_src2, resp_data;
   logic        s_dividend_tvalid, s_dividend_tready, s_divisor_tvalid, s_divisor_tready;
   logic [31:0] s_dividend_tdata, s_divisor_tdata;
   logic        s_dout_tvalid;
   logic [63:0] s_dout_tdata;
   logic        u_dividend_tvalid, u_dividend_tready, u_divisor_tvalid, u_divisor_tready;
   logic [31:0] u_dividend_tdata, u_divisor_tdata;
   logic        u_dout_tvalid;
   logic [63:0] u_dout_tdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_sched #(.DIV_W(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy),
      .s_dividend_tvalid(s_dividend_tvalid), .s_dividend_tready(s_dividend_tready),
      .s_dividend_tdata(s_dividend_tdata),
      .s_divisor_tvalid(s_divisor_tvalid), .s_divisor_tready(s_divisor_tready),
      .s_divisor_tdata(s_divisor_tdata),
      .s_dout_tvalid(s_dout_tvalid), .s_dout_tdata(s_dout_tdata),
      .u_dividend_tvalid(u_dividend_tvalid), .u_dividend_tready(u_dividend_tready),
      .u_dividend_tdata(u_dividend_tdata),
      .u_divisor_tvalid(u_divisor_tvalid), .u_divisor_tready(u_divisor_tready),
      .u_divisor_tdata(u_divisor_tdata),
      .u_dout_tvalid(u_dout_tvalid), .u_dout_tdata(u_dout_tdata)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input bit s_dvd, input bit s_dvs, input bit u_dvd, input bit u_dvs);
      s_dividend_tready = s_dvd;
      s_divisor_tready  = s_dvs;
      u_dividend_tready = u_dvd;
      u_divisor_tready  = u_dvs;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = a;
      req_src2  = b;
      step();
      req_valid = 1'b0;
   endtask

   task automatic respond(input bit sgn, input logic [63:0] d);
      if (sgn) begin
         s_dout_tvalid = 1'b1;
         s_dout_tdata  = d;
      end else begin
         u_dout_tvalid = 1'b1;
         u_dout_tdata  = d;
      end
      step();
      s_dout_tvalid = 1'b0;
      u_dout_tvalid = 1'b0;
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0;
      req_src1 = '0; req_src2 = '0; resp_ready = 1'b0;
      set_ready(0, 0, 0, 0);
      s_dout_tvalid = 1'b0; s_dout_tdata = '0;
      u_dout_tvalid = 1'b0; u_dout_tdata = '0;
      step(); step();
      reset = 1'b0;

      check("rst_req_ready",  req_ready, 1);
      check("rst_busy",       busy, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data",  resp_data, 0);
      check("rst_tvalids", {s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}, 0);

      // div.w -7 / 2 on the signed IP, 10-cycle latency
      set_ready(1, 1, 0, 0);
      issue(DIV_OP_DIV_W, 32'hFFFF_FFF9, 32'd2);
      check("t1_s_tvalids", {s_dividend_tvalid, s_divisor_tvalid}, 2'b11);
      check("t1_u_tvalids", {u_dividend_tvalid, u_divisor_tvalid}, 2'b00);
      check("t1_dvd_tdata", s_dividend_tdata, 32'hFFFF_FFF9);
      check("t1_dvs_tdata", s_divisor_tdata, 32'd2);
      check("t1_busy", busy, 1);
      check("t1_req_ready", req_ready, 0);
      step();
      check("t1_tvalids_drop", {s_dividend_tvalid, s_divisor_tvalid}, 2'b00);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen |= resp_valid;
      end
      check("t1_no_early_resp", seen, 0);
      respond(1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
      check("t1_resp_valid", resp_valid, 1);
      check("t1_resp_data", resp_data, 32'hFFFF_FFFD);
      consume();
      check("t1_busy_clear", busy, 0);
      check("t1_resp_valid_clear", resp_valid, 0);

      // mod.wu 0xFFFFFFFF / 10 on the unsigned IP
      set_ready(0, 0, 1, 1);
      issue(DIV_OP_MOD_WU, 32'hFFFF_FFFF, 32'd10);
      check("t2_u_tvalids", {u_dividend_tvalid, u_divisor_tvalid}, 2'b11);
      check("t2_s_tvalids", {s_dividend_tvalid, s_divisor_tvalid}, 2'b00);
      check("t2_dvs_tdata", u_divisor_tdata, 32'd10);
      step();
      respond(0, {32'h1999_9999, 32'd5});
      check("t2_resp_valid", resp_valid, 1);
      check("t2_resp_data", resp_data, 32'd5);
      consume();

      // mod.w 100 / 7 with dividend tready 3 cycles late; dout in SEND ignored
      set_ready(0, 1, 0, 0);
      issue(DIV_OP_MOD_W, 32'd100, 32'd7);
      check("t3_n1_tvalids", {s_dividend_tvalid, s_divisor_tvalid}, 2'b11);
      step();
      check("t3_n2_tvalids", {s_dividend_tvalid, s_divisor_tvalid}, 2'b10);
      s_dout_tvalid = 1'b1;
      s_dout_tdata  = 64'h0000_00AA_0000_00BB;
      step();
      s_dout_tvalid = 1'b0;
      check("t3_n3_dvd_tvalid", s_dividend_tvalid, 1);
      check("t3_n3_send_dout_ignored", resp_valid, 0);
      step();
      check("t3_n4_dvd_tvalid", s_dividend_tvalid, 1);
      s_dividend_tready = 1'b1;
      step();
      check("t3_n5_dvd_tvalid", s_dividend_tvalid, 0);
      respond(1, {32'd14, 32'd2});
      check("t3_resp_valid", resp_valid, 1);
      check("t3_resp_data", resp_data, 32'd2);
      consume();

      // flush in SEND with tready low: tvalid held, dout absorbed
      set_ready(0, 0, 0, 0);
      issue(DIV_OP_DIV_W, 32'd50, 32'd5);
      flush = 1'b1;
      check("t4_flush_req_ready", req_ready, 0);
      step();
      flush = 1'b0;
      check("t4_tvalid_held1", {s_dividend_tvalid, s_divisor_tvalid}, 2'b11);
      step();
      check("t4_tvalid_held2", {s_dividend_tvalid, s_divisor_tvalid}, 2'b11);
      set_ready(1, 1, 0, 0);
      step();
      check("t4_tvalid_drop", {s_dividend_tvalid, s_divisor_tvalid}, 2'b00);
      check("t4_busy_wait", busy, 1);
      respond(1, {32'd10, 32'd0});
      check("t4_no_resp", resp_valid, 0);
      check("t4_idle", busy, 0);
      set_ready(0, 0, 1, 1);
      issue(DIV_OP_DIV_WU, 32'd100, 32'd7);
      step();
      respond(0, {32'd14, 32'd2});
      check("t4_next_resp_valid", resp_valid, 1);
      check("t4_next_resp_data", resp_data, 32'd14);

      // hold in DONE for 5 cycles; spurious u dout ignored
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            u_dout_tvalid = 1'b1;
            u_dout_tdata  = 64'hDEAD_BEEF_CAFE_F00D;
         end
         step();
         u_dout_tvalid = 1'b0;
         check("t5_hold_data", resp_data, 32'd14);
         check("t5_hold_req_ready", req_ready, 0);
      end
      check("t5_hold_valid", resp_valid, 1);
      consume();
      check("t5_idle", busy, 0);

      // op==0: straight to DONE with 0, no IP traffic
      issue(4'b0000, 32'd123, 32'd456);
      check("t6_zero_resp_valid", resp_valid, 1);
      check("t6_zero_resp_data", resp_data, 0);
      check("t6_zero_tvalids", {s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}, 0);
      consume();

      // flush in DONE discards the result
      issue(4'b0000, 32'd1, 32'd1);
      flush = 1'b1;
      #1;
      check("t6_flush_done_valid", resp_valid, 0);
      step();
      flush = 1'b0;
      check("t6_flush_done_idle", busy, 0);

      // reset in WAIT, then stale dout ignored
      set_ready(1, 1, 0, 0);
      issue(DIV_OP_DIV_W, 32'd9, 32'd3);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t7_reset_busy", busy, 0);
      check("t7_reset_req_ready", req_ready, 1);
      respond(1, {32'd3, 32'd0});
      check("t7_stale_resp", resp_valid, 0);
      check("t7_stale_busy", busy, 0);

      // priority: op[0] beats op[1]; op[2] beats op[3]
      issue(4'b0011, 32'd20, 32'd3);
      check("t8_prio_signed", s_dividend_tvalid, 1);
      step();
      respond(1, {32'd6, 32'd2});
      check("t8_prio_w_data", resp_data, 32'd6);
      consume();
      set_ready(0, 0, 1, 1);
      issue(4'b1100, 32'd20, 32'd3);
      check("t8_prio_unsigned", u_dividend_tvalid, 1);
      step();
      respond(0, {32'd6, 32'd2});
      check("t8_prio_wu_data", resp_data, 32'd6);
      consume();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
